// File: rtl/io_port_bridge.sv
// io_port_bridge: peripheral-side end of the processor IO interface.
// Input side: one holding register per port, loaded by external sources
// through valid/ready and read by the core with zero latency.
// Output side: core writes are queued as {addr,data} in a FIFO that an
// external sink drains through valid/ready. The core never stalls, so
// dropped writes (ovf) and reads of empty ports (udf) are kept as sticky flags.

module io_port_bridge #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int OFDEPW = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_in,
    input  logic [$clog2(NUIOIN)-1:0]     addr_in,
    output logic [NUBITS-1:0]             io_in,
    input  logic                          out_en,
    input  logic [$clog2(NUIOOU)-1:0]     addr_out,
    input  logic [NUBITS-1:0]             data_out,
    input  logic [NUIOIN*NUBITS-1:0]      ext_in_data,
    input  logic [NUIOIN-1:0]             ext_in_vld,
    output logic [NUIOIN-1:0]             ext_in_rdy,
    output logic [NUBITS-1:0]             ext_out_data,
    output logic [$clog2(NUIOOU)-1:0]     ext_out_addr,
    output logic                          ext_out_vld,
    input  logic                          ext_out_rdy,
    input  logic                          clr_flags,
    output logic                          ovf,
    output logic                          udf,
    output logic [OFDEPW:0]               of_level
);

    localparam int AIW   = $clog2(NUIOIN);
    localparam int AOW   = $clog2(NUIOOU);
    localparam int DEPTH = 1 << OFDEPW;

    // Occupancy value meaning "every FIFO slot holds a word".
    localparam logic [OFDEPW:0] LEVEL_FULL = {1'b1, {OFDEPW{1'b0}}};

    // ------------------------------------------------------------------
    // Input path: per-port holding registers
    // ------------------------------------------------------------------
    logic [NUBITS-1:0] hold_q [NUIOIN];
    logic [NUIOIN-1:0] hold_vld_q;
    logic [NUIOIN-1:0] rd_sel;
    logic [NUIOIN-1:0] in_load;
    logic [NUIOIN-1:0] in_pop;
    logic              rd_empty;

    // Decode the core's port select and return that port's word with no latency.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rd_sel = '0;
        io_in  = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (addr_in == AIW'(k)) begin
                rd_sel[k] = 1'b1;
                io_in     = hold_q[k];
            end
        end
    end

    // Ready is pure register state: a port accepts exactly one word while empty.
    assign ext_in_rdy = ~hold_vld_q;
    assign in_load    = ext_in_vld & ~hold_vld_q;
    // A load needs vld=0 and a pop needs vld=1, so they never hit one port together.
    assign in_pop     = rd_sel & hold_vld_q & {NUIOIN{req_in}};
    assign rd_empty   = req_in & ~|(rd_sel & hold_vld_q);

    // Load holding registers from external sources; clear valid when the core reads.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            hold_vld_q <= '0;
            for (int k = 0; k < NUIOIN; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (in_load[k]) begin
                    hold_q[k]     <= ext_in_data[k*NUBITS +: NUBITS];
                    hold_vld_q[k] <= 1'b1;
                end else if (in_pop[k]) begin
                    hold_vld_q[k] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output path: {addr,data} FIFO
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [AOW-1:0]    addr;
        logic [NUBITS-1:0] data;
    } of_entry_t;

    of_entry_t         of_mem [DEPTH];
    logic [OFDEPW-1:0] wptr_q;
    logic [OFDEPW-1:0] rptr_q;
    logic [OFDEPW:0]   level_q;
    logic              of_full;
    logic              of_pop;
    logic              of_push;
    logic              of_drop;

    assign ext_out_vld = (level_q != '0);
    assign of_full     = (level_q == LEVEL_FULL);
    assign of_pop      = ext_out_vld & ext_out_rdy;
    // A pop in the same cycle frees the slot the full-FIFO push needs.
    assign of_push     = out_en & (~of_full | of_pop);
    assign of_drop     = out_en & of_full & ~of_pop;

    // Head is read straight from storage, so it cannot depend on ext_out_rdy.
    assign ext_out_addr = of_mem[rptr_q].addr;
    assign ext_out_data = of_mem[rptr_q].data;
    assign of_level     = level_q;

    // Write accepted core outputs into FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy and pointers are,
        // and a slot is never presented before it has been written.
        if (of_push) begin
            of_mem[wptr_q] <= {addr_out, data_out};
        end
    end

    // Advance pointers and occupancy; pointers wrap naturally modulo depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (of_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (of_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({of_push, of_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a new error outranks a same-cycle clear.
    // ------------------------------------------------------------------
    // Set on dropped writes / empty reads, clear on clr_flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= of_drop  | (ovf & ~clr_flags);
            udf <= rd_empty | (udf & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge that updates the design.

module tb_io_port_bridge;

    localparam int NUBITS = 32;
    localparam int NUIOIN = 8;
    localparam int NUIOOU = 8;
    localparam int OFDEPW = 3;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } ent_t;

    logic                     clk;
    logic                     rst;
    logic                     req_in;
    logic [2:0]               addr_in;
    logic [NUBITS-1:0]        io_in;
    logic                     out_en;
    logic [2:0]               addr_out;
    logic [NUBITS-1:0]        data_out;
    logic [NUIOIN*NUBITS-1:0] ext_in_data;
    logic [NUIOIN-1:0]        ext_in_vld;
    logic [NUIOIN-1:0]        ext_in_rdy;
    logic [NUBITS-1:0]        ext_out_data;
    logic [2:0]               ext_out_addr;
    logic                     ext_out_vld;
    logic                     ext_out_rdy;
    logic                     clr_flags;
    logic                     ovf;
    logic                     udf;
    logic [OFDEPW:0]          of_level;

    int errors = 0;
    int checks = 0;

    io_port_bridge #(
        .NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .OFDEPW(OFDEPW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
        .ext_in_data(ext_in_data), .ext_in_vld(ext_in_vld), .ext_in_rdy(ext_in_rdy),
        .ext_out_data(ext_out_data), .ext_out_addr(ext_out_addr),
        .ext_out_vld(ext_out_vld), .ext_out_rdy(ext_out_rdy),
        .clr_flags(clr_flags), .ovf(ovf), .udf(udf), .of_level(of_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Async reset mid-traffic: all buffered state must vanish immediately.
    task automatic test_reset();
        @(negedge clk);
        ext_in_data[2*32 +: 32] = 32'h1111_2222;
        ext_in_vld = 8'h04;
        out_en = 1'b1; addr_out = 3'd3; data_out = 32'd5;
        req_in = 1'b1; addr_in = 3'd6;
        @(negedge clk);
        ext_in_vld = '0; out_en = 1'b0; req_in = 1'b0; addr_in = 3'd2;
        #1;
        checks++; if (of_level !== 4'd1) begin errors++; $display("FAIL pre_reset_level: got %0d expected 1", of_level); end
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL pre_reset_udf: got %b expected 1", udf); end
        checks++; if (ext_in_rdy !== 8'hFB) begin errors++; $display("FAIL pre_reset_rdy: got %h expected fb", ext_in_rdy); end
        checks++; if (io_in !== 32'h1111_2222) begin errors++; $display("FAIL pre_reset_io_in: got %h expected 11112222", io_in); end
        rst = 1'b0;
        #1;
        checks++; if (ext_in_rdy !== 8'hFF) begin errors++; $display("FAIL reset_rdy: got %h expected ff", ext_in_rdy); end
        checks++; if (ext_out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", ext_out_vld); end
        checks++; if (of_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", of_level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL reset_udf: got %b expected 0", udf); end
        checks++; if (io_in !== 32'h0) begin errors++; $display("FAIL reset_hold: got %h expected 0", io_in); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ext_in_rdy !== 8'hFF) begin errors++; $display("FAIL post_reset_rdy: got %h expected ff", ext_in_rdy); end
    endtask

    // Load port 3 externally, then read it from the core.
    task automatic test_port3_load();
        @(negedge clk);
        ext_in_data[3*32 +: 32] = 32'hDEAD_BEEF;
        ext_in_vld = 8'h08;
        #1;
        checks++; if (ext_in_rdy !== 8'hFF) begin errors++; $display("FAIL p3_rdy_before: got %h expected ff", ext_in_rdy); end
        @(negedge clk);
        ext_in_vld = '0;
        #1;
        checks++; if (ext_in_rdy !== 8'hF7) begin errors++; $display("FAIL p3_rdy_loaded: got %h expected f7", ext_in_rdy); end
        addr_in = 3'd3; req_in = 1'b1;
        #1;
        checks++; if (io_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p3_io_in: got %h expected deadbeef", io_in); end
        @(negedge clk);
        req_in = 1'b0;
        #1;
        checks++; if (ext_in_rdy !== 8'hFF) begin errors++; $display("FAIL p3_rdy_after: got %h expected ff", ext_in_rdy); end
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL p3_udf: got %b expected 0", udf); end
        checks++; if (io_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p3_stale: got %h expected deadbeef", io_in); end
    endtask

    // Read of a never-loaded port, clear, and error-beats-clear.
    task automatic test_empty_read();
        @(negedge clk);
        addr_in = 3'd5; req_in = 1'b1;
        #1;
        checks++; if (io_in !== 32'h0) begin errors++; $display("FAIL empty_io_in: got %h expected 0", io_in); end
        @(negedge clk);
        req_in = 1'b0;
        #1;
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL empty_udf: got %b expected 1", udf); end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", udf); end
        req_in = 1'b1; clr_flags = 1'b1;
        @(negedge clk);
        req_in = 1'b0; clr_flags = 1'b0;
        #1;
        checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_error_wins: got %b expected 1", udf); end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear2: got %b expected 0", udf); end
    endtask

    // Three writes queue in order, head holds while stalled, then drain.
    task automatic test_output_order();
        logic [2:0]  ea [3];
        logic [31:0] ed [3];
        ea[0] = 3'd2; ed[0] = 32'd10;
        ea[1] = 3'd7; ed[1] = 32'd20;
        ea[2] = 3'd1; ed[2] = 32'd30;
        ext_out_rdy = 1'b0;
        @(negedge clk);
        out_en = 1'b1; addr_out = ea[0]; data_out = ed[0];
        #1;
        checks++; if (ext_out_vld !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b expected 0", ext_out_vld); end
        @(negedge clk);
        addr_out = ea[1]; data_out = ed[1];
        #1;
        checks++; if (ext_out_vld !== 1'b1) begin errors++; $display("FAIL vld_rise: got %b expected 1", ext_out_vld); end
        @(negedge clk);
        addr_out = ea[2]; data_out = ed[2];
        @(negedge clk);
        out_en = 1'b0;
        #1;
        checks++; if (of_level !== 4'd3) begin errors++; $display("FAIL order_level: got %0d expected 3", of_level); end
        @(negedge clk);
        #1;
        checks++; if (ext_out_addr !== 3'd2 || ext_out_data !== 32'd10) begin errors++; $display("FAIL head_stable: got (%0d,%0d) expected (2,10)", ext_out_addr, ext_out_data); end
        ext_out_rdy = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                @(negedge clk);
                #1;
            end
            checks++; if (ext_out_vld !== 1'b1 || ext_out_addr !== ea[j] || ext_out_data !== ed[j]) begin errors++; $display("FAIL order_head%0d: got vld=%b (%0d,%0d) expected (%0d,%0d)", j, ext_out_vld, ext_out_addr, ext_out_data, ea[j], ed[j]); end
        end
        @(negedge clk);
        #1;
        checks++; if (ext_out_vld !== 1'b0 || of_level !== 4'd0) begin errors++; $display("FAIL order_empty: got vld=%b level=%0d expected 0/0", ext_out_vld, of_level); end
        ext_out_rdy = 1'b0;
    endtask

    // Nine writes into depth 8, flag clear, then push-at-full with a pop.
    task automatic test_overflow();
        ext_out_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            out_en = 1'b1;
            addr_out = (i == 8) ? 3'd0 : 3'(i);
            data_out = (i == 8) ? 32'h999 : 32'(100 + i);
        end
        @(negedge clk);
        out_en = 1'b0;
        #1;
        checks++; if (of_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", of_level); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        checks++; if (ext_out_addr !== 3'd0 || ext_out_data !== 32'd100) begin errors++; $display("FAIL ovf_head: got (%0d,%0d) expected (0,100)", ext_out_addr, ext_out_data); end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        out_en = 1'b1; addr_out = 3'd5; data_out = 32'd108; ext_out_rdy = 1'b1;
        @(negedge clk);
        out_en = 1'b0;
        #1;
        checks++; if (of_level !== 4'd8) begin errors++; $display("FAIL full_push_pop_level: got %0d expected 8", of_level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_push_pop_ovf: got %b expected 0", ovf); end
        for (int j = 1; j < 8; j++) begin
            if (j > 1) begin
                @(negedge clk);
                #1;
            end
            checks++; if (ext_out_addr !== 3'(j) || ext_out_data !== 32'(100 + j)) begin errors++; $display("FAIL ovf_drain%0d: got (%0d,%0d) expected (%0d,%0d)", j, ext_out_addr, ext_out_data, j, 100 + j); end
        end
        @(negedge clk);
        #1;
        checks++; if (ext_out_addr !== 3'd5 || ext_out_data !== 32'd108) begin errors++; $display("FAIL ovf_last: got (%0d,%0d) expected (5,108)", ext_out_addr, ext_out_data); end
        @(negedge clk);
        #1;
        checks++; if (ext_out_vld !== 1'b0 || of_level !== 4'd0) begin errors++; $display("FAIL ovf_empty: got vld=%b level=%0d expected 0/0", ext_out_vld, of_level); end
        ext_out_rdy = 1'b0;
    endtask

    // Twenty writes across pointer wrap with toggling ready, plus concurrent input traffic.
    task automatic test_wrap_concurrency();
        ent_t q[$];
        ent_t e;
        int   pops = 0;
        @(negedge clk);
        ext_in_data[1*32 +: 32] = 32'h1111_0001;
        ext_in_vld = 8'h02;
        @(negedge clk);
        ext_in_vld = '0;
        #1;
        checks++; if (ext_in_rdy !== 8'hFD) begin errors++; $display("FAIL wrap_p1_load: got %h expected fd", ext_in_rdy); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            out_en = (i % 3 != 2);
            addr_out = 3'(i);
            data_out = 32'h5000 + 32'(i);
            ext_out_rdy = (i % 2 == 1);
            req_in = 1'b0;
            ext_in_vld = '0;
            if (i == 3) begin
                ext_in_data[0 +: 32] = 32'hAAAA_0000;
                ext_in_vld = 8'h01;
                req_in = 1'b1; addr_in = 3'd1;
            end
            if (i == 6) begin
                req_in = 1'b1; addr_in = 3'd0;
            end
            #1;
            checks++; if (ext_out_vld !== (q.size() != 0)) begin errors++; $display("FAIL wrap_vld%0d: got %b expected %b", i, ext_out_vld, q.size() != 0); end
            if (ext_out_vld && ext_out_rdy && q.size() != 0) begin
                e = q.pop_front();
                pops++;
                checks++; if (ext_out_addr !== e.a || ext_out_data !== e.d) begin errors++; $display("FAIL wrap_head%0d: got (%0d,%h) expected (%0d,%h)", i, ext_out_addr, ext_out_data, e.a, e.d); end
            end
            if (out_en) q.push_back('{a: addr_out, d: data_out});
            if (i == 3) begin
                checks++; if (io_in !== 32'h1111_0001) begin errors++; $display("FAIL wrap_p1_read: got %h expected 11110001", io_in); end
            end
            if (i == 4) begin
                checks++; if (ext_in_rdy !== 8'hFE) begin errors++; $display("FAIL wrap_indep: got %h expected fe", ext_in_rdy); end
            end
            if (i == 6) begin
                checks++; if (io_in !== 32'hAAAA_0000) begin errors++; $display("FAIL wrap_p0_read: got %h expected aaaa0000", io_in); end
            end
            if (i == 7) begin
                checks++; if (ext_in_rdy !== 8'hFF) begin errors++; $display("FAIL wrap_rdy_all: got %h expected ff", ext_in_rdy); end
            end
        end
        @(negedge clk);
        out_en = 1'b0; req_in = 1'b0; ext_out_rdy = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) begin
            #1;
            e = q.pop_front();
            pops++;
            checks++; if (ext_out_vld !== 1'b1 || ext_out_addr !== e.a || ext_out_data !== e.d) begin errors++; $display("FAIL drain_head: got vld=%b (%0d,%h) expected (%0d,%h)", ext_out_vld, ext_out_addr, ext_out_data, e.a, e.d); end
            @(negedge clk);
        end
        #1;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL drain_bound: got %0d left expected 0", q.size()); end
        checks++; if (ext_out_vld !== 1'b0 || of_level !== 4'd0) begin errors++; $display("FAIL wrap_empty: got vld=%b level=%0d expected 0/0", ext_out_vld, of_level); end
        checks++; if (pops != 20) begin errors++; $display("FAIL wrap_count: got %0d expected 20", pops); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL wrap_flags: got ovf=%b udf=%b expected 0/0", ovf, udf); end
        ext_out_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_in = 1'b0; addr_in = '0;
        out_en = 1'b0; addr_out = '0; data_out = '0;
        ext_in_data = '0; ext_in_vld = '0;
        ext_out_rdy = 1'b0; clr_flags = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_port3_load();
        test_empty_read();
        test_output_order();
        test_overflow();
        test_wrap_concurrency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
